seg7_ascii_scan: RTL

//  Multi-digit, time-multiplexed ASCII 7-segment display driver for the mood-lighting status display.
//  - Holds a NUM_DIGITS-deep character buffer, written one character per clock.
//  - Scans the digits one at a time and decodes ASCII to segments internally.
//  - Drives the shared segment bus and per-digit anodes, with dead-time between digits against ghosting.
//  - Host logic (e.g. colour/mode readout "R255") writes characters; this block owns all display timing.

---
 rtl/seg7_ascii_scan.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/seg7_ascii_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_ascii_scan                                              |
// | Description : Time-multiplexed ASCII 7-segment driver with character      |
// |               buffer, internal decode and inter-digit dead-time.           |
// |               Optional macro SEG7_SCROLL_EN adds frame-paced scrolling.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_ascii_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int DEAD_CYC      = 2,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [7:0]                    wr_char,
  input  logic                          blank,
`ifdef SEG7_SCROLL_EN
  input  logic                          scroll_en,
`endif
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_end
);

  localparam int c_aw = $clog2(NUM_DIGITS);
  localparam int c_cw = $clog2(SCAN_DIV);
  localparam logic [c_aw:0]   c_nd    = (c_aw+1)'(NUM_DIGITS);
  localparam logic [c_aw-1:0] c_dlast = c_aw'(NUM_DIGITS-1);
  localparam logic [c_cw-1:0] c_clast = c_cw'(SCAN_DIV-1);
  localparam logic [c_cw-1:0] c_dead  = c_cw'(DEAD_CYC);

  typedef enum logic [0:0] {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } state_t;

  localparam state_t c_st_rst = (DEAD_CYC > 0) ? ST_DEAD : ST_ON;

  logic [7:0]            r_buf [NUM_DIGITS];
  logic [c_cw-1:0]       r_cnt;
  logic [c_aw-1:0]       r_dig;
  state_t                r_state;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_fe;

  logic                  w_wrap;
  logic                  w_wr_ok;
  logic [c_cw-1:0]       w_cnt_nxt;
  logic [c_aw-1:0]       w_dig_nxt;
  state_t                w_state_nxt;
  logic [c_aw-1:0]       w_sel;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_onehot;

  // Lowercase folds to uppercase; anything without a glyph is blank.
  function automatic logic [6:0] f_decode(input logic [7:0] c);
    logic [7:0] u;
    u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    case (u)
      8'h30:   f_decode = 7'b0000001;
      8'h31:   f_decode = 7'b1001111;
      8'h32:   f_decode = 7'b0010010;
      8'h33:   f_decode = 7'b0000110;
      8'h34:   f_decode = 7'b1001100;
      8'h35:   f_decode = 7'b0100100;
      8'h36:   f_decode = 7'b0100000;
      8'h37:   f_decode = 7'b0001111;
      8'h38:   f_decode = 7'b0000000;
      8'h39:   f_decode = 7'b0000100;
      8'h41:   f_decode = 7'b0001000;
      8'h42:   f_decode = 7'b1100000;
      8'h43:   f_decode = 7'b0110001;
      8'h45:   f_decode = 7'b0110000;
      8'h46:   f_decode = 7'b0111000;
      8'h47:   f_decode = 7'b0100001;
      8'h48:   f_decode = 7'b1001000;
      8'h4C:   f_decode = 7'b1110001;
      8'h50:   f_decode = 7'b0011000;
      8'h52:   f_decode = 7'b1111010;
      8'h55:   f_decode = 7'b1000001;
      8'h2D:   f_decode = 7'b1111110;
      default: f_decode = 7'b1111111;
    endcase
  endfunction

  assign w_wrap      = (r_cnt == c_clast);
  assign w_cnt_nxt   = w_wrap ? '0 : (r_cnt + 1'b1);
  assign w_state_nxt = (w_cnt_nxt < c_dead) ? ST_DEAD : ST_ON;
  assign w_wr_ok     = wr_en && ({1'b0, wr_addr} < c_nd);
  assign w_onehot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_dig;

  always_comb begin
    w_dig_nxt = r_dig;
    if (w_wrap) begin
      w_dig_nxt = (r_dig == c_dlast) ? '0 : (r_dig + 1'b1);
    end
  end

`ifdef SEG7_SCROLL_EN
  localparam int c_fw = $clog2(SCROLL_FRAMES + 1);
  localparam logic [c_fw-1:0] c_flast = c_fw'(SCROLL_FRAMES-1);

  logic [c_aw-1:0] r_ofs;
  logic [c_fw-1:0] r_fcnt;
  logic [c_aw:0]   w_sum;

  assign w_sum = {1'b0, r_dig} + {1'b0, r_ofs};
  assign w_sel = (w_sum >= c_nd) ? c_aw'(w_sum - c_nd) : c_aw'(w_sum);

  // Offset steps on the frame_end pulse itself, so a full frame is shown per offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ofs  <= '0;
      r_fcnt <= '0;
    end else if (scroll_en && r_fe) begin
      if (r_fcnt == c_flast) begin
        r_fcnt <= '0;
        r_ofs  <= (r_ofs == c_dlast) ? '0 : (r_ofs + 1'b1);
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end
`else
  assign w_sel = r_dig;
`endif

  assign w_seg = f_decode(r_buf[w_sel]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_buf[i] <= 8'h20;
      end
    end else if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_char;
    end
  end

  // Outputs register the phase of the current (digit, count) pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_dig   <= '0;
      r_state <= c_st_rst;
      r_seg   <= 7'h7F;
      r_an    <= '1;
      r_fe    <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_dig   <= w_dig_nxt;
      r_state <= w_state_nxt;
      r_fe    <= (w_dig_nxt == c_dlast) && (w_cnt_nxt == c_clast);
      case (r_state)
        ST_ON: begin
          r_seg <= w_seg;
          r_an  <= blank ? '1 : ~w_onehot;
        end
        default: begin
          r_seg <= 7'h7F;
          r_an  <= '1;
        end
      endcase
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign frame_end = r_fe;

endmodule
`default_nettype wire
